game_st_uart_tx: RTL and testbench

Serial status reporter that sits directly downstream of the game FSM. It consumes the 8-bit ASCII game status byte: 'n' none, 'X' X wins, 'O' O wins, 'C' cat's game, 'E' error. Whenever that byte changes, or on request, it sends the byte over a UART 8N1 line, optionally followed by CR LF. The line feeds the board's USB-UART bridge so game outcome is visible on a host terminal.

---
 rtl/game_st_uart_tx_if.sv | 17 +
 rtl/game_st_uart_tx.sv | 155 +++++++++++++++
 tb/tb_game_st_uart_tx.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_st_uart_tx_if.sv
// Status-reporter bus: the game FSM side drives game_st/send_now, the
// reporter drives the UART line and its status flags.
//   game_st  : ASCII status byte (level)
//   send_now : one-cycle resend request
//   tx       : UART serial out, idle high
//   busy     : status sequence on the line
//   overrun  : one-cycle pulse when a queued status is replaced
interface game_st_uart_tx_if;
   logic [7:0] game_st;
   logic       send_now;
   logic       tx;
   logic       busy;
   logic       overrun;

   modport master (output game_st, send_now, input tx, busy, overrun);
   modport slave  (input game_st, send_now, output tx, busy, overrun);
endinterface

// File: rtl/game_st_uart_tx.sv
// Serial status reporter. Sends the game status byte as UART 8N1 whenever it
// changes or on send_now, optionally followed by CR LF. One status can be
// queued while a sequence is on the line; replacing a queued status with a
// different value pulses overrun.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : game_st_uart_tx_if.slave (game_st, send_now in; tx, busy, overrun out)
//
// state | meaning
// IDLE  | line idle, waiting for a request
// START | start bit (tx=0)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (tx=1), then next char, pending status or idle
module game_st_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter bit SEND_CRLF    = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   game_st_uart_tx_if.slave   bus
);

   localparam int            BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [1:0]    LAST_IDX  = SEND_CRLF ? 2'd2 : 2'd0;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    idx_q, idx_d;
   logic [7:0]    byte_q, byte_d;
   logic [7:0]    last_q, last_d;
   logic [7:0]    pend_val_q, pend_val_d;
   logic          pend_flag_q, pend_flag_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          overrun_q, overrun_d;

   logic req;
   logic baud_wrap;

   always_comb begin
      req         = (bus.game_st != last_q) || bus.send_now;
      baud_wrap   = (baud_q == BAUD_LAST);
      state_d     = state_q;
      baud_d      = baud_q;
      bit_d       = bit_q;
      idx_d       = idx_q;
      byte_d      = byte_q;
      last_d      = last_q;
      pend_val_d  = pend_val_q;
      pend_flag_d = pend_flag_q;
      tx_d        = tx_q;
      busy_d      = busy_q;
      overrun_d   = 1'b0;

      if (state_q == IDLE) begin
         if (req) begin
            byte_d  = bus.game_st;
            last_d  = bus.game_st;
            state_d = START;
            baud_d  = '0;
            bit_d   = 3'd0;
            idx_d   = 2'd0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
         end
      end else begin
         if (req) begin
            last_d      = bus.game_st;
            pend_val_d  = bus.game_st;
            pend_flag_d = 1'b1;
            if (pend_flag_q && (pend_val_q != bus.game_st))
               overrun_d = 1'b1;
         end

         baud_d = baud_wrap ? '0 : baud_q + BW'(1);

         if (baud_wrap) begin
            unique case (state_q)
               START: begin
                  state_d = DATA;
                  bit_d   = 3'd0;
                  tx_d    = byte_q[0];
               end
               DATA: begin
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end else begin
                     tx_d = byte_q[bit_d];
                  end
               end
               STOP: begin
                  if (idx_q != LAST_IDX) begin
                     idx_d   = idx_q + 2'd1;
                     byte_d  = (idx_q == 2'd0) ? 8'h0D : 8'h0A;
                     state_d = START;
                     tx_d    = 1'b0;
                  end else if (pend_flag_d) begin
                     // a request arriving on this very edge is already in
                     // pend_val_d, so the newest status wins
                     byte_d      = pend_val_d;
                     pend_flag_d = 1'b0;
                     idx_d       = 2'd0;
                     state_d     = START;
                     tx_d        = 1'b0;
                  end else begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_q       <= 3'd0;
         idx_q       <= 2'd0;
         byte_q      <= 8'h00;
         last_q      <= 8'h00;
         pend_val_q  <= 8'h00;
         pend_flag_q <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         idx_q       <= idx_d;
         byte_q      <= byte_d;
         last_q      <= last_d;
         pend_val_q  <= pend_val_d;
         pend_flag_q <= pend_flag_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.tx      = tx_q;
   assign bus.busy    = busy_q;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_game_st_uart_tx.sv
// Bench for game_st_uart_tx: two instances (with and without CR LF) against a
// sequence-position reference model, plus directed window counts.
module tb_game_st_uart_tx;

   localparam int C    = 4;
   localparam int SEQ0 = 30 * C;
   localparam int SEQ1 = 10 * C;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   game_st_uart_tx_if if0 ();
   game_st_uart_tx_if if1 ();

   game_st_uart_tx #(.CLKS_PER_BIT(C), .SEND_CRLF(1'b1)) dut0 (
      .clk(clk), .reset(reset), .bus(if0)
   );
   game_st_uart_tx #(.CLKS_PER_BIT(C), .SEND_CRLF(1'b0)) dut1 (
      .clk(clk), .reset(reset), .bus(if1)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: a sequence is a run of SEQ cycles; position in it picks
   // character, bit slot and so the line level.
   bit         m_busy [2];
   int         m_pos  [2];
   logic [7:0] m_cur  [2];
   logic [7:0] m_last [2];
   logic [7:0] m_pv   [2];
   bit         m_pf   [2];
   bit         m_ov   [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic [7:0] gs;
         logic       sn;
         int         sl;
         bit         req;
         gs = (d == 1) ? if1.game_st  : if0.game_st;
         sn = (d == 1) ? if1.send_now : if0.send_now;
         sl = (d == 1) ? SEQ1 : SEQ0;
         m_ov[d] = 1'b0;
         if (reset) begin
            m_busy[d] = 1'b0;
            m_pos[d]  = 0;
            m_cur[d]  = 8'h00;
            m_last[d] = 8'h00;
            m_pv[d]   = 8'h00;
            m_pf[d]   = 1'b0;
         end else begin
            req = (gs != m_last[d]) || sn;
            if (!m_busy[d]) begin
               if (req) begin
                  m_busy[d] = 1'b1;
                  m_pos[d]  = 0;
                  m_cur[d]  = gs;
                  m_last[d] = gs;
               end
            end else begin
               if (req) begin
                  if (m_pf[d] && m_pv[d] != gs) m_ov[d] = 1'b1;
                  m_pf[d]   = 1'b1;
                  m_pv[d]   = gs;
                  m_last[d] = gs;
               end
               m_pos[d]++;
               if (m_pos[d] == sl) begin
                  if (m_pf[d]) begin
                     m_pf[d]  = 1'b0;
                     m_cur[d] = m_pv[d];
                     m_pos[d] = 0;
                  end else begin
                     m_busy[d] = 1'b0;
                  end
               end
            end
         end
      end
   end

   function automatic logic exp_tx(input int d);
      int         ch;
      int         b;
      logic [7:0] v;
      if (!m_busy[d]) return 1'b1;
      ch = m_pos[d] / (10 * C);
      b  = (m_pos[d] % (10 * C)) / C;
      v  = (ch == 0) ? m_cur[d] : ((ch == 1) ? 8'h0D : 8'h0A);
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return v[b-1];
   endfunction

   int busy_cnt [2];
   int rise_cnt [2];
   int ov_cnt   [2];
   bit prev_b   [2];
   int s_busy   [2];
   int s_rise   [2];
   int s_ov     [2];

   task automatic tick();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         logic t, b, o;
         t = (d == 1) ? if1.tx      : if0.tx;
         b = (d == 1) ? if1.busy    : if0.busy;
         o = (d == 1) ? if1.overrun : if0.overrun;
         check((d == 1) ? "tx1"   : "tx0",   32'(t), 32'(exp_tx(d)));
         check((d == 1) ? "busy1" : "busy0", 32'(b), 32'(m_busy[d]));
         check((d == 1) ? "ovr1"  : "ovr0",  32'(o), 32'(m_ov[d]));
         if (b) busy_cnt[d]++;
         if (b && !prev_b[d]) rise_cnt[d]++;
         if (o) ov_cnt[d]++;
         prev_b[d] = b;
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic snap();
      for (int d = 0; d < 2; d++) begin
         s_busy[d] = busy_cnt[d];
         s_rise[d] = rise_cnt[d];
         s_ov[d]   = ov_cnt[d];
      end
   endtask

   logic [7:0] codes [5];

   initial begin
      codes = '{8'h6E, 8'h58, 8'h4F, 8'h43, 8'h45};
      for (int d = 0; d < 2; d++) begin
         busy_cnt[d] = 0; rise_cnt[d] = 0; ov_cnt[d] = 0; prev_b[d] = 1'b0;
      end
      reset        = 1'b1;
      if0.game_st  = 8'h6E;
      if0.send_now = 1'b0;
      if1.game_st  = 8'h6E;
      if1.send_now = 1'b0;
      run(3);
      check("rst_tx",   32'(if0.tx),      32'd1);
      check("rst_busy", 32'(if0.busy),    32'd0);
      check("rst_ovr",  32'(if0.overrun), 32'd0);

      // 1: power-up send of 'n' CR LF
      reset = 1'b0;
      snap();
      tick();
      check("t1_fall", 32'(if0.tx), 32'd0);
      run(199);
      check("t1_busy",   32'(busy_cnt[0] - s_busy[0]), 32'd120);
      check("t1_starts", 32'(rise_cnt[0] - s_rise[0]), 32'd1);
      check("t1_tx_idle", 32'(if0.tx), 32'd1);

      // 2 and 6: status change on both instances
      if0.game_st = 8'h58;
      if1.game_st = 8'h43;
      snap();
      run(200);
      check("t2_busy",   32'(busy_cnt[0] - s_busy[0]), 32'd120);
      check("t2_starts", 32'(rise_cnt[0] - s_rise[0]), 32'd1);
      check("t2_ovr",    32'(ov_cnt[0] - s_ov[0]),     32'd0);
      check("t6_busy",   32'(busy_cnt[1] - s_busy[1]), 32'd40);
      check("t6_starts", 32'(rise_cnt[1] - s_rise[1]), 32'd1);

      // 3: two changes during one sequence, the queued 'E' is replaced by 'C'
      snap();
      if0.send_now = 1'b1;
      tick();
      if0.send_now = 1'b0;
      run(10);
      if0.game_st = 8'h45;
      run(10);
      if0.game_st = 8'h43;
      run(300);
      check("t3_busy",   32'(busy_cnt[0] - s_busy[0]), 32'd240);
      check("t3_starts", 32'(rise_cnt[0] - s_rise[0]), 32'd1);
      check("t3_ovr",    32'(ov_cnt[0] - s_ov[0]),     32'd1);

      // 4: send_now alone, then send_now together with a change
      if0.game_st = 8'h4F;
      run(200);
      snap();
      if0.send_now = 1'b1;
      tick();
      if0.send_now = 1'b0;
      run(199);
      check("t4a_busy",   32'(busy_cnt[0] - s_busy[0]), 32'd120);
      check("t4a_starts", 32'(rise_cnt[0] - s_rise[0]), 32'd1);
      snap();
      if0.send_now = 1'b1;
      if0.game_st  = 8'h58;
      tick();
      if0.send_now = 1'b0;
      run(199);
      check("t4b_busy",   32'(busy_cnt[0] - s_busy[0]), 32'd120);
      check("t4b_starts", 32'(rise_cnt[0] - s_rise[0]), 32'd1);

      // 5: reset during data bit 3
      if0.send_now = 1'b1;
      tick();
      if0.send_now = 1'b0;
      run(17);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_tx",   32'(if0.tx),   32'd1);
      check("t5_busy", 32'(if0.busy), 32'd0);
      snap();
      tick();
      check("t5_restart_tx",   32'(if0.tx),   32'd0);
      check("t5_restart_busy", 32'(if0.busy), 32'd1);
      run(199);
      check("t5_busy", 32'(busy_cnt[0] - s_busy[0]), 32'd120);

      // randomized traffic against the model
      repeat (3000) begin
         if ($urandom_range(0, 39) == 0) if0.game_st = codes[$urandom_range(0, 4)];
         if ($urandom_range(0, 39) == 0) if1.game_st = codes[$urandom_range(0, 4)];
         if0.send_now = ($urandom_range(0, 59) == 0);
         if1.send_now = ($urandom_range(0, 59) == 0);
         reset        = ($urandom_range(0, 1999) == 0);
         tick();
      end
      reset        = 1'b0;
      if0.send_now = 1'b0;
      if1.send_now = 1'b0;
      run(300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
